// File: rtl/debug_unit.sv
// UART-driven debug controller: run/step/reset a pipeline and dump a 20-byte
// snapshot (pc, instr, alu, mem, cycle count) MSB first over the transmitter.
module debug_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        pipe_en,
  output logic        pipe_reset,
  input  logic [31:0] test_pc,
  input  logic [31:0] test_instr,
  input  logic [31:0] test_alu_result,
  input  logic [31:0] test_mem_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    CAPTURE,
    SEND
  } state_t;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [7:0]  CMD_RUN    = 8'h63;
  localparam logic [7:0]  CMD_STEP   = 8'h73;
  localparam logic [7:0]  CMD_RESET  = 8'h72;
  localparam logic [7:0]  CMD_DUMP   = 8'h64;
  localparam logic [4:0]  LAST_BYTE  = 5'd19;

  state_t      state;
  state_t      state_nxt;
  logic        cmd_reset;
  logic [31:0] cyc_cnt;
  logic [4:0]  byte_idx;
  logic [31:0] snap [5];
  logic [31:0] cur_word;
  logic [7:0]  cur_byte;

  always_comb begin
    state_nxt = state;
    cmd_reset = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_RUN:   state_nxt = RUN;
            CMD_STEP:  state_nxt = STEP;
            CMD_RESET: cmd_reset = 1'b1;
            CMD_DUMP:  state_nxt = CAPTURE;
            default:   state_nxt = IDLE;
          endcase
        end
      end
      RUN:     if (test_instr == HALT_INSTR) state_nxt = CAPTURE;
      STEP:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (tx_ready && byte_idx == LAST_BYTE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by reset so the pipeline sees a clean stop in the very
  // cycle reset is raised, before the state register has been cleared.
  always_comb begin
    pipe_en    = !reset && (state == RUN || state == STEP);
    busy       = !reset && (state != IDLE);
    tx_valid   = !reset && (state == SEND);
    pipe_reset = reset || cmd_reset;
  end

  always_comb begin
    case (byte_idx[4:2])
      3'd0:    cur_word = snap[0];
      3'd1:    cur_word = snap[1];
      3'd2:    cur_word = snap[2];
      3'd3:    cur_word = snap[3];
      3'd4:    cur_word = snap[4];
      default: cur_word = '0;
    endcase
    case (byte_idx[1:0])
      2'd0:    cur_byte = cur_word[31:24];
      2'd1:    cur_byte = cur_word[23:16];
      2'd2:    cur_byte = cur_word[15:8];
      default: cur_byte = cur_word[7:0];
    endcase
    tx_data = tx_valid ? cur_byte : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      byte_idx <= '0;
      for (int unsigned i = 0; i < 5; i++) snap[i] <= '0;
    end else begin
      state <= state_nxt;

      if (cmd_reset)
        cyc_cnt <= '0;
      else if (pipe_en && cyc_cnt != '1)
        cyc_cnt <= cyc_cnt + 32'd1;

      if (state == CAPTURE) begin
        snap[0] <= test_pc;
        snap[1] <= test_instr;
        snap[2] <= test_alu_result;
        snap[3] <= test_mem_data;
        snap[4] <= cyc_cnt;
      end

      if (state == SEND && tx_ready)
        byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + 5'd1;
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: a pipeline stub feeds the observation ports and a
// scoreboard queue holds the expected dump bytes.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        pipe_en;
  logic        pipe_reset;
  logic [31:0] test_pc, test_instr, test_alu_result, test_mem_data;
  logic        busy;

  debug_unit dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pipe_en(pipe_en), .pipe_reset(pipe_reset),
    .test_pc(test_pc), .test_instr(test_instr),
    .test_alu_result(test_alu_result), .test_mem_data(test_mem_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int en_cnt = 0;
  int acc_cnt = 0;
  logic bp_mode = 1'b0;
  logic [7:0] exp_q[$];

  // Pipeline stub: the fourth fetch (pc 3) is the HALT sentinel and the stub
  // stalls on it, so instr stays 0xFFFFFFFF until the pipeline is reset.
  logic [31:0] pc = '0;
  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return (p == 32'd3) ? 32'hFFFF_FFFF : (32'h1300_0000 | p);
  endfunction
  assign test_pc         = pc * 32'd4;
  assign test_instr      = instr_of(pc);
  assign test_alu_result = pc * 32'd3 + 32'd7;
  assign test_mem_data   = 32'hA5A5_0000 ^ pc;

  always @(posedge clk) begin
    if (pipe_reset) pc <= '0;
    else if (pipe_en && instr_of(pc) != 32'hFFFF_FFFF) pc <= pc + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_snap(input logic [31:0] p, input logic [31:0] cnt);
    logic [31:0] w [5];
    w[0] = p * 32'd4;
    w[1] = instr_of(p);
    w[2] = p * 32'd3 + 32'd7;
    w[3] = 32'hA5A5_0000 ^ p;
    w[4] = cnt;
    for (int i = 0; i < 5; i++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w[i] >> (8 * b)));
  endtask

  // tx_ready pattern 1,0,0,1 when backpressure is on
  logic [3:0] bp_pat = 4'b1001;
  int bp_k = 0;
  always @(posedge clk) begin
    #1;
    tx_ready = bp_mode ? bp_pat[bp_k] : 1'b1;
    bp_k = (bp_k + 1) % 4;
  end

  logic       hold_v = 1'b0;
  logic [7:0] hold_d = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (pipe_en) en_cnt++;
      if (hold_v && tx_valid) check("stall_stable", 32'(tx_data), 32'(hold_d));
      hold_v = tx_valid && !tx_ready;
      hold_d = tx_data;
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) check("extra_byte", 32'(tx_data), 32'hxx);
        else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    #1;
    if (b == 8'h72) check("cmd_pipe_reset", 32'(pipe_reset), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic        pre_r;
    logic [7:0]  cmd;
    logic        bp;
    int unsigned exp_en;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        dumps;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 8'h73, 1'b0, 1, 32'd1, 32'd1, 1'b1};
    vecs[1] = '{1'b0, 8'h41, 1'b0, 0, 32'd1, 32'd1, 1'b0};
    vecs[2] = '{1'b0, 8'h64, 1'b1, 0, 32'd1, 32'd1, 1'b1};
    vecs[3] = '{1'b0, 8'h73, 1'b0, 1, 32'd2, 32'd2, 1'b1};
    vecs[4] = '{1'b1, 8'h63, 1'b0, 4, 32'd3, 32'd4, 1'b1};
    vecs[5] = '{1'b0, 8'h63, 1'b0, 1, 32'd3, 32'd5, 1'b1};

    tick();
    check("rst_pipe_reset", 32'(pipe_reset), 32'd1);
    check("rst_pipe_en", 32'(pipe_en), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_pipe_reset", 32'(pipe_reset), 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_r) begin
        send(8'h72);
        check("r_busy", 32'(busy), 32'd0);
      end
      en_cnt = 0;
      bp_mode = vecs[v].bp;
      if (vecs[v].dumps) push_snap(vecs[v].exp_pc, vecs[v].exp_cnt);
      send(vecs[v].cmd);
      check("cmd_busy", 32'(busy), 32'(vecs[v].dumps));
      check("cmd_pipe_reset_low", 32'(pipe_reset), 32'd0);
      wait_idle();
      bp_mode = 1'b0;
      check("en_cycles", 32'(en_cnt), 32'(vecs[v].exp_en));
      check("bytes_left", 32'(exp_q.size()), 32'd0);
      check("done_tx_valid", 32'(tx_valid), 32'd0);
    end

    // 's' arriving mid-dump must be dropped
    en_cnt = 0;
    push_snap(32'd3, 32'd5);
    send(8'h64);
    tick();
    tick();
    send(8'h73);
    wait_idle();
    check("ign_en_cycles", 32'(en_cnt), 32'd0);
    check("ign_bytes_left", 32'(exp_q.size()), 32'd0);

    // reset after byte 7 aborts the dump for good
    push_snap(32'd3, 32'd5);
    acc_cnt = 0;
    send(8'h64);
    for (int n = 0; n < 100 && acc_cnt < 8; n++) tick();
    check("acc_before_rst", 32'(acc_cnt), 32'd8);
    reset = 1'b1;
    #1;
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_pipe_reset", 32'(pipe_reset), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("after_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("after_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tick();
    tick();
    check("no_resume", 32'(acc_cnt), 32'd8);
    push_snap(32'd0, 32'd0);
    send(8'h64);
    wait_idle();
    check("fresh_bytes_left", 32'(exp_q.size()), 32'd0);

    // saturation: preload the counter near the top, then run 3 cycles
    send(8'h72);
    push_snap(32'd1, 32'd1);
    send(8'h73);
    wait_idle();
    force dut.cyc_cnt = 32'hFFFF_FFFE;
    #2;
    release dut.cyc_cnt;
    en_cnt = 0;
    push_snap(32'd3, 32'hFFFF_FFFF);
    send(8'h63);
    wait_idle();
    check("sat_en_cycles", 32'(en_cnt), 32'd3);
    check("sat_bytes_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit; reset is synchronous and active-high.
REQ-003 The block SHALL have the port rx_data, input, 8 bits, the command byte from the UART receiver.
REQ-004 The block SHALL have the port rx_valid, input, 1 bit; a one-cycle strobe that marks rx_data as valid.
REQ-005 The block SHALL have the port tx_data, output, 8 bits, the byte sent to the UART transmitter.
REQ-006 The block SHALL have the port tx_valid, output, 1 bit, marking tx_data as valid.
REQ-007 The block SHALL have the port tx_ready, input, 1 bit; the transmitter accepts a byte on any cycle where tx_valid and tx_ready are both 1.
REQ-008 The block SHALL have the port pipe_en, output, 1 bit, the clock-enable for all pipeline stages and latches.
REQ-009 The block SHALL have the port pipe_reset, output, 1 bit, the synchronous reset driven to the pipeline.
REQ-010 The block SHALL have the ports test_pc, test_instr, test_alu_result and test_mem_data, inputs, 32 bits each, the pipeline's observation outputs.
REQ-011 The block SHALL have the port busy, output, 1 bit; it is 1 in every state except IDLE.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, RUN, STEP, CAPTURE, SEND.
REQ-013 IDLE SHALL decode rx_data only when rx_valid=1, as follows:
- 0x63 'c': go to RUN.
- 0x73 's': go to STEP.
- 0x72 'r': assert pipe_reset for one cycle, clear cyc_cnt, stay in IDLE.
- 0x64 'd': go to CAPTURE.
- Any other byte: ignore it.
REQ-014 In every state other than IDLE, rx_valid SHALL be ignored; no command queue exists.
REQ-015 pipe_en SHALL be 1 only in RUN and STEP.
REQ-016 STEP SHALL last exactly one cycle, so pipe_en is high for exactly one cycle; the next state is CAPTURE.
REQ-017 RUN SHALL hold pipe_en=1 until it samples test_instr==32'hFFFF_FFFF (HALT sentinel) in a RUN cycle.
REQ-018 The RUN cycle in which the HALT sentinel is sampled SHALL count as enabled, and the next state SHALL be CAPTURE, so pipe_en drops on the following cycle.
REQ-019 cyc_cnt SHALL be a 32-bit counter incremented on every cycle with pipe_en=1, and SHALL saturate at 32'hFFFF_FFFF without wrapping.
REQ-020 CAPTURE SHALL last one cycle and SHALL register a 20-byte snapshot in this order: test_pc, test_instr, test_alu_result, test_mem_data, cyc_cnt; the next state is SEND.
REQ-021 SEND SHALL emit the 20 snapshot bytes, each word MSB first, using a 5-bit byte index that runs 0..19.
REQ-022 tx_valid SHALL be 1 throughout SEND.
REQ-023 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-024 The byte index SHALL advance only on a cycle where tx_valid and tx_ready are both 1.
REQ-025 After byte 19 is accepted, the FSM SHALL return to IDLE with tx_valid=0 in the next cycle.
REQ-026 If tx_ready is held at 1, SEND SHALL take exactly 20 cycles.
REQ-027 Snapshot registers SHALL NOT change during SEND, even if the pipeline inputs change.
REQ-028 pipe_reset SHALL NOT be asserted in any state other than IDLE.

Reset
REQ-029 reset=1 SHALL force the state to IDLE and clear cyc_cnt, the byte index and the snapshot to 0.
REQ-030 During reset=1, outputs SHALL be tx_valid=0, tx_data=0, pipe_en=0, busy=0.
REQ-031 During reset=1, pipe_reset SHALL equal 1, so reset is propagated to the pipeline.
REQ-032 reset asserted mid-RUN or mid-SEND SHALL abort the operation on the next edge with no further tx bytes emitted.
REQ-033 A partially sent snapshot SHALL NOT be resumed after reset.

Verification
REQ-034 Step, tx_ready=1: 'r' then 's' -> pipe_en high exactly 1 cycle; 20 bytes follow, last four = 00 00 00 01; busy drops after the last byte.
REQ-035 Run-to-HALT: program whose 4th fetch is 0xFFFFFFFF, send 'c' -> pipe_en high 4 cycles; bytes 4..7 = FF FF FF FF; bytes 16..19 = 00 00 00 04.
REQ-036 Backpressure: tx_ready toggled 1,0,0,1 during 'd' -> no byte duplicated or skipped; tx_data unchanged across stalls; 20 accepts in total.
REQ-037 Ignored commands: 0x41 in IDLE, and 's' sent during SEND -> no state change, no extra step, snapshot intact.
REQ-038 Reset mid-SEND after byte 7: reset for 1 cycle -> tx_valid=0 next cycle, cyc_cnt=0, IDLE; a following 'd' dumps a fresh snapshot with bytes 16..19 = 0.
REQ-039 Saturation: force cyc_cnt to 0xFFFFFFFE, then run 3 cycles -> reported count = FF FF FF FF.
